// File: rtl/msk_sym_pkg.sv
// Shared types and width helpers for the msk_sym_sync symbol timing recovery block.
package msk_sym_pkg;

  typedef logic [0:0] state_t;
  localparam state_t S_ACQ = 1'b0;
  localparam state_t S_TRK = 1'b1;

  // Encoding doubles as the debug step_o pulse value
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_ADV  = 2'b01,
    STEP_RET  = 2'b10
  } step_t;

  localparam int DEF_WIQ   = 16;
  localparam int DEF_N_TRK = 16;

  function automatic int mag_w(input int wiq);
    return wiq + 1;
  endfunction

  function automatic int err_w(input int wiq);
    return wiq + 2;
  endfunction

  function automatic int acc_w(input int wiq, input int n_trk);
    return wiq + 3 + $clog2(n_trk);
  endfunction

  localparam int MAG_W = mag_w(DEF_WIQ);
  localparam int ERR_W = err_w(DEF_WIQ);
  localparam int ACC_W = acc_w(DEF_WIQ, DEF_N_TRK);

endpackage

// File: rtl/msk_el_ted.sv
// Early-late gate timing error: e = (|I|+|Q|)late - (|I|+|Q|)early, with saturating abs.
module msk_el_ted
  import msk_sym_pkg::*;
#(
  parameter int WIQ = DEF_WIQ
) (
  input  logic signed [WIQ-1:0]   early_i,
  input  logic signed [WIQ-1:0]   early_q,
  input  logic signed [WIQ-1:0]   late_i,
  input  logic signed [WIQ-1:0]   late_q,
  output logic signed [WIQ+1:0]   err
);

  localparam int MW = mag_w(WIQ);

  logic [MW-1:0] m_early;
  logic [MW-1:0] m_late;

  // The most negative code has no positive twin, so it is clamped to the max positive
  function automatic logic [WIQ-1:0] sat_abs(input logic signed [WIQ-1:0] x);
    if (x == {1'b1, {(WIQ-1){1'b0}}})
      return {1'b0, {(WIQ-1){1'b1}}};
    else if (x[WIQ-1])
      return -x;
    else
      return x;
  endfunction

  assign m_early = {1'b0, sat_abs(early_i)} + {1'b0, sat_abs(early_q)};
  assign m_late  = {1'b0, sat_abs(late_i)}  + {1'b0, sat_abs(late_q)};
  assign err     = $signed({1'b0, m_late}) - $signed({1'b0, m_early});

endmodule

// File: rtl/msk_sym_sync.sv
// Symbol timing recovery/decimator: early-late TED, skip/stall phase counter, ACQ/TRK lock FSM.
// Optional debug outputs ted_err_o/step_o are built when MSK_SYM_SYNC_DBG_EN is defined.
module msk_sym_sync
  import msk_sym_pkg::*;
#(
  parameter int OSF      = 20,
  parameter int WIQ      = DEF_WIQ,
  parameter int EL_OFF   = 2,
  parameter int N_ACQ    = 4,
  parameter int N_TRK    = DEF_N_TRK,
  parameter int THRESH   = 2048,
  parameter int LOCK_WIN = 8,
  parameter int LOSS_WIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [WIQ-1:0]      i_in,
  input  logic signed [WIQ-1:0]      q_in,
  input  logic                       iq_val_i,
  output logic signed [WIQ-1:0]      i_sym,
  output logic signed [WIQ-1:0]      q_sym,
  output logic                       sym_val_o,
  output logic                       lock_o,
  output logic [$clog2(OSF)-1:0]     phase_o
`ifdef MSK_SYM_SYNC_DBG_EN
  ,
  output logic signed [WIQ+1:0]      ted_err_o,
  output logic [1:0]                 step_o
`endif
);

  localparam int CW  = $clog2(OSF);
  localparam int EW  = err_w(WIQ);
  localparam int AW  = acc_w(WIQ, N_TRK);
  localparam int DL  = 2 * EL_OFF;
  localparam int WCW = $clog2(N_TRK) + 1;
  localparam int LKW = $clog2(LOCK_WIN + 1);
  localparam int LSW = $clog2(LOSS_WIN + 1);

  localparam logic [CW-1:0]        CNT_LAST = CW'(OSF - 1);
  localparam logic [CW-1:0]        CNT_DEC  = CW'(OSF / 2 + EL_OFF);
  localparam logic signed [AW-1:0] THR_POS  = AW'(THRESH);
  localparam logic signed [AW-1:0] THR_NEG  = AW'(-THRESH);

  logic [CW-1:0]          cnt;
  logic signed [WIQ-1:0]  dl_i [DL];
  logic signed [WIQ-1:0]  dl_q [DL];
  logic signed [EW-1:0]   err;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_next;
  logic [WCW-1:0]         win_cnt;
  logic [WCW-1:0]         win_last;
  logic [LKW-1:0]         nostep_cnt;
  logic [LSW-1:0]         loss_cnt;
  state_t                 state;
  step_t                  pending;
  step_t                  win_step;
  logic                   dec;
  logic                   wrap;
  logic                   win_end;

  // The incoming sample acts as tap 0, so the stored line only needs 2*EL_OFF registers
  msk_el_ted #(
    .WIQ(WIQ)
  ) u_ted (
    .early_i (dl_i[DL-1]),
    .early_q (dl_q[DL-1]),
    .late_i  (i_in),
    .late_q  (q_in),
    .err     (err)
  );

  assign dec      = iq_val_i && (cnt == CNT_DEC);
  assign wrap     = iq_val_i && (cnt == CNT_LAST);
  assign win_last = (state == S_ACQ) ? WCW'(N_ACQ - 1) : WCW'(N_TRK - 1);
  assign win_end  = dec && (win_cnt == win_last);
  assign acc_next = acc + {{(AW-EW){err[EW-1]}}, err};
  assign lock_o   = (state == S_TRK);
  assign phase_o  = cnt;

  always_comb begin
    win_step = STEP_NONE;
    if (acc_next > THR_POS)
      win_step = STEP_ADV;
    else if (acc_next < THR_NEG)
      win_step = STEP_RET;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DL; k++) begin
        dl_i[k] <= '0;
        dl_q[k] <= '0;
      end
    end else if (iq_val_i) begin
      dl_i[0] <= i_in;
      dl_q[0] <= q_in;
      for (int k = 1; k < DL; k++) begin
        dl_i[k] <= dl_i[k-1];
        dl_q[k] <= dl_q[k-1];
      end
    end
  end

  // RET needs no extra state: clearing pending while holding OSF-1 makes the next valid wrap normally
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pending <= STEP_NONE;
    end else begin
      if (iq_val_i) begin
        if (cnt == CNT_LAST) begin
          case (pending)
            STEP_ADV: cnt <= CW'(1);
            STEP_RET: cnt <= CNT_LAST;
            default:  cnt <= '0;
          endcase
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (wrap)
        pending <= STEP_NONE;
      if (win_end)
        pending <= win_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (dec) begin
      if (win_end) begin
        acc     <= '0;
        win_cnt <= '0;
      end else begin
        acc     <= acc_next;
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ACQ;
      nostep_cnt <= '0;
      loss_cnt   <= '0;
    end else if (win_end) begin
      if (state == S_ACQ) begin
        if (win_step != STEP_NONE) begin
          nostep_cnt <= '0;
        end else if (nostep_cnt == LKW'(LOCK_WIN - 1)) begin
          state      <= S_TRK;
          nostep_cnt <= '0;
          loss_cnt   <= '0;
        end else begin
          nostep_cnt <= nostep_cnt + 1'b1;
        end
      end else begin
        if (win_step == STEP_NONE) begin
          loss_cnt <= '0;
        end else if (loss_cnt == LSW'(LOSS_WIN - 1)) begin
          state      <= S_ACQ;
          loss_cnt   <= '0;
          nostep_cnt <= '0;
        end else begin
          loss_cnt <= loss_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_val_o <= 1'b0;
      i_sym     <= '0;
      q_sym     <= '0;
    end else begin
      sym_val_o <= dec;
      if (dec) begin
        i_sym <= dl_i[EL_OFF-1];
        q_sym <= dl_q[EL_OFF-1];
      end
    end
  end

`ifdef MSK_SYM_SYNC_DBG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ted_err_o <= '0;
      step_o    <= 2'b00;
    end else begin
      if (dec)
        ted_err_o <= err;
      step_o <= wrap ? pending : STEP_NONE;
    end
  end
`endif

endmodule

// File: tb/tb_msk_sym_sync.sv
// Directed bench for msk_sym_sync: reset, aligned/gapped trains, forced ADV/RET, saturation, mid-TRK reset.
module tb_msk_sym_sync;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic               iq_val_i = 1'b0;
  logic signed [15:0] i_sym;
  logic signed [15:0] q_sym;
  logic               sym_val_o;
  logic               lock_o;
  logic [4:0]         phase_o;
`ifdef MSK_SYM_SYNC_DBG_EN
  logic signed [17:0] ted_err_o;
  logic [1:0]         step_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] pat_i = 16'hB2E5;
  logic [15:0] pat_q = 16'h6C1D;

  always #5 clk = ~clk;

  msk_sym_sync dut (
    .clk       (clk),
    .rst       (rst),
    .i_in      (i_in),
    .q_in      (q_in),
    .iq_val_i  (iq_val_i),
    .i_sym     (i_sym),
    .q_sym     (q_sym),
    .sym_val_o (sym_val_o),
    .lock_o    (lock_o),
    .phase_o   (phase_o)
`ifdef MSK_SYM_SYNC_DBG_EN
    ,
    .ted_err_o (ted_err_o),
    .step_o    (step_o)
`endif
  );

  // Expected counter label of valid sample n; modes 1/2 have a hand-placed ADV/RET at sample 80
  function automatic int lab_of(input int mode, input int n);
    case (mode)
      1:       return (n < 80)  ? n % 20 : (n + 1) % 20;
      2:       return (n < 80)  ? n % 20 : (n + 19) % 20;
      3:       return (n < 160) ? n % 20 : (n + 1) % 20;
      default: return n % 20;
    endcase
  endfunction

  function automatic int peak_of(input int mode, input int n);
    if (mode == 1 && n < 80) return 11;
    if (mode == 2 && n < 80) return 9;
    return 10;
  endfunction

  function automatic logic signed [15:0] pulse(input int lab, input int peak, input int base,
                                               input logic neg);
    int d;
    int v;
    d = (lab > peak) ? lab - peak : peak - lab;
    v = base - d * (base / 16);
    if (neg) v = -v;
    return v[15:0];
  endfunction

  task automatic drive(input logic signed [15:0] si, input logic signed [15:0] sq,
                       input logic sv);
    i_in     = si;
    q_in     = sq;
    iq_val_i = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    iq_val_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(16'sh1234, -16'sd77, 1'b1);
    drive(16'sh8000, 16'sh7FFF, 1'b1);
    do_reset();
    n_cmp++;
    if (i_sym !== 16'sd0 || q_sym !== 16'sd0) begin
      n_err++;
      $display("[TB] FAIL reset_iq got i=%0d q=%0d exp 0 0", i_sym, q_sym);
    end
    n_cmp++;
    if (sym_val_o !== 1'b0 || lock_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_flags got val=%b lock=%b exp 0 0", sym_val_o, lock_o);
    end
    n_cmp++;
    if (phase_o !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL reset_phase got %0d exp 0", phase_o);
    end
  endtask

  task automatic test_pulse_train(input int mode, input logic gapped, input int nsym,
                                  input int lock_k);
    int n;
    int k;
    int lab;
    int cyc;
    int last_cyc;
    logic signed [15:0] si;
    logic signed [15:0] sq;
    logic signed [15:0] ot_i;
    logic signed [15:0] ot_q;
    logic               exp_lock;
`ifdef MSK_SYM_SYNC_DBG_EN
    logic [1:0]         exp_step;
`endif
    n = 0; k = 0; cyc = 0; last_cyc = 0; ot_i = '0; ot_q = '0;
    while (k < nsym) begin
      lab = lab_of(mode, n);
      si  = pulse(lab, peak_of(mode, n), 16000, pat_i[(n / 20) % 16]);
      sq  = pulse(lab, peak_of(mode, n), 8000,  pat_q[(n / 20) % 16]);
      n_cmp++;
      if (phase_o !== 5'(lab)) begin
        n_err++;
        $display("[TB] FAIL phase mode=%0d n=%0d got %0d exp %0d", mode, n, phase_o, lab);
      end
      if (lab == 10) begin
        ot_i = si;
        ot_q = sq;
      end
      drive(si, sq, 1'b1);
      cyc++;
`ifdef MSK_SYM_SYNC_DBG_EN
      exp_step = (n == 79 && mode == 1) ? 2'b01 : (n == 79 && mode == 2) ? 2'b10 : 2'b00;
      n_cmp++;
      if (step_o !== exp_step) begin
        n_err++;
        $display("[TB] FAIL step mode=%0d n=%0d got %b exp %b", mode, n, step_o, exp_step);
      end
`endif
      if (lab == 12) begin
        k++;
        n_cmp++;
        if (sym_val_o !== 1'b1 || i_sym !== ot_i || q_sym !== ot_q) begin
          n_err++;
          $display("[TB] FAIL symbol mode=%0d k=%0d got val=%b i=%0d q=%0d exp 1 %0d %0d",
                   mode, k, sym_val_o, i_sym, q_sym, ot_i, ot_q);
        end
        exp_lock = (k >= lock_k);
        n_cmp++;
        if (lock_o !== exp_lock) begin
          n_err++;
          $display("[TB] FAIL lock mode=%0d k=%0d got %b exp %b", mode, k, lock_o, exp_lock);
        end
        if (gapped && k > 1) begin
          n_cmp++;
          if (cyc - last_cyc != 40) begin
            n_err++;
            $display("[TB] FAIL spacing k=%0d got %0d exp 40", k, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
      end else begin
        n_cmp++;
        if (sym_val_o !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL stray_val mode=%0d n=%0d got %b exp 0", mode, n, sym_val_o);
        end
      end
      n++;
      if (gapped) begin
        drive(16'sh8000, 16'sh3039, 1'b0);
        cyc++;
        n_cmp++;
        if (sym_val_o !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL gap_val n=%0d got %b exp 0", n, sym_val_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid_trk();
    n_cmp++;
    if (lock_o !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL pre_reset_lock got %b exp 1", lock_o);
    end
    rst      = 1'b1;
    i_in     = 16'sh4321;
    q_in     = -16'sd999;
    iq_val_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (i_sym !== 16'sd0 || q_sym !== 16'sd0 || sym_val_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_out got i=%0d q=%0d val=%b exp 0 0 0", i_sym, q_sym, sym_val_o);
    end
    n_cmp++;
    if (lock_o !== 1'b0 || phase_o !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL midrst_state got lock=%b phase=%0d exp 0 0", lock_o, phase_o);
    end
    rst      = 1'b0;
    iq_val_i = 1'b0;
  endtask

  // Window 1: e=32767-32255=512, acc=2048 (not above threshold); window 2: e=513, acc=2052 -> ADV
  task automatic test_saturation();
    int lab;
    logic signed [15:0] si;
    logic signed [15:0] ot_i;
`ifdef MSK_SYM_SYNC_DBG_EN
    logic signed [17:0] exp_e;
`endif
    do_reset();
    ot_i = '0;
    for (int n = 0; n < 200; n++) begin
      lab = lab_of(3, n);
      si  = 16'sd0;
      if (n < 160) begin
        if (lab == 12 || lab == 10)
          si = 16'sh8000;
        else if (lab == 8)
          si = (n < 80) ? 16'sd32255 : 16'sd32254;
      end
      n_cmp++;
      if (phase_o !== 5'(lab)) begin
        n_err++;
        $display("[TB] FAIL sat_phase n=%0d got %0d exp %0d", n, phase_o, lab);
      end
      if (lab == 10) ot_i = si;
      drive(si, 16'sd0, 1'b1);
      if (lab == 12) begin
        n_cmp++;
        if (sym_val_o !== 1'b1 || i_sym !== ot_i || q_sym !== 16'sd0) begin
          n_err++;
          $display("[TB] FAIL sat_symbol n=%0d got val=%b i=%0d q=%0d exp 1 %0d 0",
                   n, sym_val_o, i_sym, q_sym, ot_i);
        end
`ifdef MSK_SYM_SYNC_DBG_EN
        exp_e = (n < 80) ? 18'sd512 : (n < 160) ? 18'sd513 : 18'sd0;
        n_cmp++;
        if (ted_err_o !== exp_e) begin
          n_err++;
          $display("[TB] FAIL sat_err n=%0d got %0d exp %0d", n, ted_err_o, exp_e);
        end
`endif
      end
    end
  endtask

  initial begin
    $display("[TB] msk_sym_sync directed bench start");
    test_reset();
    test_pulse_train(0, 1'b0, 40, 32);
    test_reset_mid_trk();
    test_pulse_train(0, 1'b0, 40, 32);
    do_reset();
    test_pulse_train(0, 1'b1, 36, 32);
    do_reset();
    test_pulse_train(1, 1'b0, 40, 36);
    do_reset();
    test_pulse_train(2, 1'b0, 40, 36);
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msk_sym_sync.md
Name: msk_sym_sync

Overview:
- Symbol timing recovery and decimator directly downstream of the matched filter.
- Consumes 20x-oversampled filtered I/Q (200 MHz samples, 10 MHz symbols) and runs an early-late gate timing error detector.
- Corrects timing by skipping or stalling its sample-phase counter, and emits one on-time I/Q pair per symbol to the demod/slicer, with a lock flag.

Parameters:
- OSF, 20, samples per symbol
- WIQ, 16, input/output sample width (signed)
- EL_OFF, 2, early/late offset in samples from on-time (1..OSF/2-1)
- N_ACQ, 4, symbols per averaging window in ACQ (power of 2)
- N_TRK, 16, symbols per averaging window in TRK (power of 2)
- THRESH, 2048, accumulator magnitude that triggers one phase step
- LOCK_WIN, 8, consecutive no-step windows needed to enter TRK
- LOSS_WIN, 4, consecutive step windows in TRK that force return to ACQ

Ports:
- clk  in  1  system clock, 200 MHz
- rst  in  1  synchronous, active-high reset
- i_in  in  WIQ  matched-filter I, signed
- q_in  in  WIQ  matched-filter Q, signed
- iq_val_i  in  1  input sample valid
- i_sym  out  WIQ  on-time I at symbol rate
- q_sym  out  WIQ  on-time Q at symbol rate
- sym_val_o  out  1  one-cycle strobe, symbol output valid
- lock_o  out  1  high while FSM is in TRK
- phase_o  out  $clog2(OSF)  current sample-phase counter

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: i_sym, q_sym, sym_val_o, lock_o, phase_o = 0. Counter cnt = 0, delay line cleared, accumulator = 0, window counters = 0, pending step = none, FSM = ACQ. rst mid-window discards all partial state.
- State advances only on iq_val_i = 1. Gaps in valid freeze cnt, the delay line and the accumulator.
- Delay line: 2*EL_OFF+1 samples, shifted on each valid. d[0] is the newest sample.
- Decision point is the valid sample where cnt == OSF/2+EL_OFF. At that point:
  - late = d[0]; on-time = d[EL_OFF]; early = d[2*EL_OFF].
  - Next cycle: sym_val_o = 1, with i_sym/q_sym = on-time. Latency is 1 clk after the deciding valid sample.
- Magnitude:
  - m = |I| + |Q|, WIQ+1 bits unsigned.
  - |-2^(WIQ-1)| saturates to 2^(WIQ-1)-1.
- Error and accumulation:
  - e = m_late - m_early, signed WIQ+2 bits.
  - acc += e at each decision; acc is signed, WIQ+3+$clog2(N_TRK) bits, no overflow by construction.
- Window end (after N_ACQ symbols in ACQ, N_TRK in TRK):
  - acc > THRESH: pending = ADV. acc < -THRESH: pending = RET. Otherwise none.
  - acc is then cleared.
  - At most one step per window.
- Counter:
  - cnt increments mod OSF on each valid.
  - A pending step is applied at the wrap (cnt == OSF-1 with valid), then cleared.
  - ADV: cnt goes to 1 (one sample skipped).
  - RET: cnt holds at OSF-1 for one more valid, then goes to 0.
  - If a window ends on the same sample as a wrap, the new pending step waits for the next wrap.
- FSM (2 states):
  - ACQ -> TRK after LOCK_WIN consecutive windows with no step.
  - TRK -> ACQ after LOSS_WIN consecutive windows with a step; any no-step window resets that count.
  - Any step in ACQ resets the no-step count.
  - On a state change, acc and the window counter are cleared.
- phase_o = cnt, registered.
- Output I/Q are passed through unmodified; no gain.

Optional Feature:
- Macro: MSK_SYM_SYNC_DBG_EN.
- Defined: adds outputs ted_err_o (WIQ+2, e of the last decision, updated with sym_val_o) and step_o (2 bits: 01 = ADV applied, 10 = RET applied, one-cycle pulse at the wrap).
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package msk_sym_pkg:
  - state typedef {S_ACQ, S_TRK}
  - step typedef {STEP_NONE, STEP_ADV, STEP_RET}
  - width helper constants (MAG_W, ERR_W, ACC_W)
- Sub-module msk_el_ted: combinational magnitude and error computation from early/late I/Q, including the saturating abs.
- Top level holds the delay line, counter, accumulator and FSM.

Test Plan:
- Aligned input: ±16000 NRZ-like pulses peaking at cnt == 10 with OSF = 20 → e ≈ 0 every symbol, no steps, lock_o rises after 4*8 = 32 symbols; i_sym = ±16000 pattern.
- Peak 3 samples late → three ADV steps, one per ACQ window (step_o = 01 with DBG), then lock; on-time output matches the peak value.
- Peak 3 samples early → three RET steps, with cnt showing an OSF-1 hold of 2 valids each time.
- Gapped valid (iq_val_i toggling 1010…) on aligned input → identical symbol sequence to the continuous case; sym_val_o spacing doubles.
- Input -32768 on I → m saturates to 32767 and no overflow in e.
- Reset asserted mid-window in TRK → next cycle all outputs 0, FSM = ACQ, lock_o = 0; reacquires identically to the first run.
